// File: rtl/fpu_rr_arbiter.sv
// Round-robin front end that shares one FPU between NUM_REQ requesters.
// One operation in flight; the result returns as a one-cycle pulse to its owner.
module fpu_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int C_OP    = 32,
    parameter int C_RM    = 3,
    parameter int C_CMD   = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ*C_OP-1:0]  req_op_a_i,
    input  logic [NUM_REQ*C_OP-1:0]  req_op_b_i,
    input  logic [NUM_REQ*C_RM-1:0]  req_rm_i,
    input  logic [NUM_REQ*C_CMD-1:0] req_cmd_i,
    output logic [NUM_REQ-1:0]       resp_valid_o,
    output logic [C_OP-1:0]          resp_result_o,
    output logic [ID_W-1:0]          resp_id_o,
    output logic [C_OP-1:0]          fpu_op_a_o,
    output logic [C_OP-1:0]          fpu_op_b_o,
    output logic [C_RM-1:0]          fpu_rm_o,
    output logic [C_CMD-1:0]         fpu_cmd_o,
    output logic                     fpu_enable_o,
    input  logic                     fpu_valid_i,
    input  logic [C_OP-1:0]          fpu_result_i,
    output logic                     busy_o
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [C_OP-1:0]      op_a_q, op_a_d;
    logic [C_OP-1:0]      op_b_q, op_b_d;
    logic [C_RM-1:0]      rm_q, rm_d;
    logic [C_CMD-1:0]     cmd_q, cmd_d;
    logic [C_OP-1:0]      result_q, result_d;
    logic [ID_W-1:0]      resp_id_q, resp_id_d;
    logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;
    logic [NUM_REQ-1:0]   ready_comb;

    logic                 grant_valid;
    logic [ID_W-1:0]      grant_id;
    logic [ID_W-1:0]      scan_id;

    // Scan from the highest offset down so the requester closest to rr_ptr wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        scan_id     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_id = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (req_valid_i[scan_id]) begin
                grant_valid = 1'b1;
                grant_id    = scan_id;
            end
        end
    end

    always_comb begin
        // NOTE: every variable gets a default before the case so no latch is inferred.
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        id_d         = id_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        rm_d         = rm_q;
        cmd_d        = cmd_q;
        result_d     = result_q;
        resp_id_d    = resp_id_q;
        resp_valid_d = '0;
        ready_comb   = '0;

        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    ready_comb[grant_id] = 1'b1;
                    id_d    = grant_id;
                    op_a_d  = req_op_a_i[int'(grant_id)*C_OP +: C_OP];
                    op_b_d  = req_op_b_i[int'(grant_id)*C_OP +: C_OP];
                    rm_d    = req_rm_i[int'(grant_id)*C_RM +: C_RM];
                    cmd_d   = req_cmd_i[int'(grant_id)*C_CMD +: C_CMD];
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (fpu_valid_i) begin
                    result_d           = fpu_result_i;
                    resp_id_d          = id_q;
                    resp_valid_d[id_q] = 1'b1;
                    rr_ptr_d           = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
                    state_d            = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            id_q         <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            rm_q         <= '0;
            cmd_q        <= '0;
            result_q     <= '0;
            resp_id_q    <= '0;
            resp_valid_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            id_q         <= id_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            rm_q         <= rm_d;
            cmd_q        <= cmd_d;
            result_q     <= result_d;
            resp_id_q    <= resp_id_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    // The grant strobe is combinational from req_valid_i, so it must be masked while reset is held.
    assign req_ready_o   = rst_n ? ready_comb : '0;
    assign resp_valid_o  = resp_valid_q;
    assign resp_result_o = result_q;
    assign resp_id_o     = resp_id_q;
    assign fpu_op_a_o    = op_a_q;
    assign fpu_op_b_o    = op_b_q;
    assign fpu_rm_o      = rm_q;
    assign fpu_cmd_o     = cmd_q;
    assign fpu_enable_o  = (state_q == BUSY);
    assign busy_o        = (state_q == BUSY);

endmodule
